dsp_mac_sequencer: RTL



---
 rtl/dsp_mac_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer
// Drives an external DSP48E1 slice (AREG=BREG=MREG=PREG=1, OPMODEREG=1) through
// N-term signed multiply-accumulate jobs. Operand pairs arrive on a valid/ready
// stream, the accumulated P is captured when the last-term tag leaves a 3-stage
// tag pipe, and the sum is offered on a valid/ready result port.
// Optional build macro MACSEQ_SAT32_EN: clamp the captured sum to the signed
// 32-bit range (sign-extended to 48 bits) and raise res_sat when clamping.
module dsp_mac_sequencer #(
    parameter int MAX_LEN = 256,
    parameter int LEN_W   = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_a,
    input  logic [17:0]      in_b,
    output logic [29:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [4:0]       dsp_inmode,
    output logic [3:0]       dsp_alumode,
    output logic [6:0]       dsp_opmode,
    input  logic [47:0]      dsp_p,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [47:0]      res_data,
    output logic             res_sat,
    output logic             busy
);

    // OPMODE encodings: Z/Y/X = 000/01/01 loads M, 010/01/01 adds M to P,
    // 010/00/00 feeds P back unchanged.
    localparam logic [6:0] OP_LOAD = 7'b000_0101;
    localparam logic [6:0] OP_ACC  = 7'b010_0101;
    localparam logic [6:0] OP_HOLD = 7'b010_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [LEN_W-1:0]   cnt_reg;
    logic               first_reg;
    logic [29:0]        a_reg;
    logic [17:0]        b_reg;
    logic [6:0]         slot_op_reg;
    logic               slot_last_reg;
    logic [6:0]         opmode_reg;
    logic [2:0]         tag_reg;
    logic [47:0]        res_data_reg;
    logic               res_sat_reg;
    logic [47:0]        cap_data;
    logic               cap_sat;

    logic               issue;
    logic               accept;
    logic               last_beat;
    logic               len_ok;
    logic               capture;

    assign issue     = (state_reg == ISSUE);
    assign accept    = in_valid && issue;
    assign last_beat = accept && (cnt_reg == LEN_W'(1));
    assign len_ok    = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    // The tag sits in its last stage exactly while P holds the final sum.
    assign capture   = (state_reg == DRAIN) && tag_reg[2];

    assign in_ready    = issue;
    assign busy        = (state_reg != IDLE);
    assign res_valid   = (state_reg == RESULT);
    assign res_data    = res_data_reg;
    assign res_sat     = res_sat_reg;
    assign dsp_a       = a_reg;
    assign dsp_b       = b_reg;
    assign dsp_opmode  = opmode_reg;
    assign dsp_inmode  = 5'b00000;
    assign dsp_alumode = 4'b0000;

    // Next-state logic of the job sequencer.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start && len_ok) state_next = ISSUE;
            ISSUE:   if (last_beat) state_next = DRAIN;
            DRAIN:   if (tag_reg[2]) state_next = RESULT;
            RESULT:  if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register, remaining-term counter and first-term flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            first_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == IDLE) && start && len_ok) begin
                cnt_reg   <= cfg_len;
                first_reg <= 1'b1;
            end else if (accept) begin
                cnt_reg   <= cnt_reg - LEN_W'(1);
                first_reg <= 1'b0;
            end
        end
    end

    // Operand registers toward the slice's A/B inputs, loaded on each accepted beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
        end else if (accept) begin
            a_reg <= {{5{in_a[24]}}, in_a};
            b_reg <= in_b;
        end
    end

    // Slot stage: decide the operation for the operand slot, then delay it one
    // more cycle so OPMODE reaches the slice's OPMODEREG alongside MREG.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_op_reg   <= OP_HOLD;
            slot_last_reg <= 1'b0;
            opmode_reg    <= OP_HOLD;
        end else begin
            slot_op_reg   <= accept ? (first_reg ? OP_LOAD : OP_ACC) : OP_HOLD;
            slot_last_reg <= last_beat;
            opmode_reg    <= slot_op_reg;
        end
    end

    // Last-term tag pipe, aligned with OPMODE so its exit matches the final P.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_reg <= '0;
        end else begin
            tag_reg <= {tag_reg[1:0], slot_last_reg};
        end
    end

`ifdef MACSEQ_SAT32_EN
    localparam logic signed [47:0] SAT_MAX = 48'sh0000_7FFF_FFFF;
    localparam logic signed [47:0] SAT_MIN = 48'shFFFF_8000_0000;

    // Clamp P to the signed 32-bit range on its way into the result register.
    always_comb begin
        cap_data = dsp_p;
        cap_sat  = 1'b0;
        if ($signed(dsp_p) > SAT_MAX) begin
            cap_data = SAT_MAX;
            cap_sat  = 1'b1;
        end else if ($signed(dsp_p) < SAT_MIN) begin
            cap_data = SAT_MIN;
            cap_sat  = 1'b1;
        end
    end
`else
    // Raw 48-bit P passes straight through; no overflow indication.
    always_comb begin
        cap_data = dsp_p;
        cap_sat  = 1'b0;
    end
`endif

    // Result register: sample P when the tag exits, hold it through RESULT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_data_reg <= '0;
            res_sat_reg  <= 1'b0;
        end else if (capture) begin
            res_data_reg <= cap_data;
            res_sat_reg  <= cap_sat;
        end
    end

endmodule
